osd_input_sequencer: RTL and testbench

Converts one-shot requests into timed, non-overlapping pulses on the arcade core's coin, start and game-reset inputs. Requests come from OSD trigger bits in `status` (T1 coin, T2 start 1, T3 start 2, T5 reset) and from joystick/keyboard coin and start buttons. Sits between `hps_io` and `target_top` in `emu`. Arbitrates the shared credit inputs so every request produces exactly one pulse long enough for the game's input polling, with a guaranteed gap between pulses.

---
 rtl/osd_input_sequencer.sv | 156 +++++++++++++++
 tb/tb_osd_input_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/osd_input_sequencer.sv
// Turns OSD trigger bits and coin/start buttons into timed, non-overlapping
// credit pulses for the arcade core, plus a timed game reset.
module osd_input_sequencer #(
    parameter int PULSE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES   = 2_500_000,
    parameter int RESET_CYCLES = 65_536,
    parameter int CNT_W        = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] status,
    input  logic        btn_coin,
    input  logic        btn_start1,
    input  logic        btn_start2,
    output logic        coin_out,
    output logic        start1_out,
    output logic        start2_out,
    output logic        game_reset,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_RST   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [6:0]       prev_r;
    logic [2:0]       pend_r;   // {start2, start1, coin}
    logic [2:0]       out_r;    // {start2, start1, coin}; doubles as the latched selection
    logic             game_reset_r;
    logic             busy_r;

    logic [6:0]       in_s;
    logic [6:0]       edge_s;
    logic [2:0]       req_s;
    logic             rst_req_s;
    logic [2:0]       grant_s;
    logic             unused_s;

    assign in_s      = {btn_start2, btn_start1, btn_coin, status[5], status[3], status[2], status[1]};
    assign edge_s    = in_s & ~prev_r;
    assign req_s     = {edge_s[2] | edge_s[6], edge_s[1] | edge_s[5], edge_s[0] | edge_s[4]};
    assign rst_req_s = edge_s[3];
    assign unused_s  = ^{status[31:6], status[4], status[0]};

    // Fixed-priority grant (coin > start1 > start2), only from IDLE and never alongside a game reset.
    always_comb begin
        grant_s = 3'b000;
        if ((state_r == ST_IDLE) && !rst_req_s) begin
            if (pend_r[0]) begin
                grant_s = 3'b001;
            end else if (pend_r[1]) begin
                grant_s = 3'b010;
            end else if (pend_r[2]) begin
                grant_s = 3'b100;
            end else begin
                grant_s = 3'b000;
            end
        end else begin
            grant_s = 3'b000;
        end
    end

    // Edge history, pending flags and the pulse/gap/reset sequencer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_r       <= in_s;
            pend_r       <= 3'b000;
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            out_r        <= 3'b000;
            game_reset_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            prev_r <= in_s;

            // A set beats a same-cycle grant clear; a game reset discards everything.
            if (rst_req_s || (state_r == ST_RST)) begin
                pend_r <= 3'b000;
            end else begin
                pend_r <= req_s | (pend_r & ~grant_s);
            end

            if (rst_req_s) begin
                state_r      <= ST_RST;
                cnt_r        <= RESET_LOAD;
                out_r        <= 3'b000;
                game_reset_r <= 1'b1;
                busy_r       <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (grant_s != 3'b000) begin
                            state_r <= ST_PULSE;
                            cnt_r   <= PULSE_LOAD;
                            out_r   <= grant_s;
                            busy_r  <= 1'b1;
                        end else begin
                            busy_r  <= 1'b0;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_LOAD;
                            out_r   <= 3'b000;
                        end else begin
                            cnt_r   <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r   <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_RST: begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r      <= ST_IDLE;
                            game_reset_r <= 1'b0;
                            busy_r       <= 1'b0;
                        end else begin
                            cnt_r        <= cnt_r - CNT_ONE;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= CNT_ZERO;
                        out_r        <= 3'b000;
                        game_reset_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign coin_out   = out_r[0];
    assign start1_out = out_r[1];
    assign start2_out = out_r[2];
    assign game_reset = game_reset_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_osd_input_sequencer.sv
// Directed scenarios for osd_input_sequencer with PULSE=4, GAP=3, RESET=8;
// every cycle's outputs are compared against hand-derived windows.
module tb_osd_input_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] status;
    logic        btn_coin;
    logic        btn_start1;
    logic        btn_start2;
    logic        coin_out;
    logic        start1_out;
    logic        start2_out;
    logic        game_reset;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    osd_input_sequencer #(
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (3),
        .RESET_CYCLES(8),
        .CNT_W       (24)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .status    (status),
        .btn_coin  (btn_coin),
        .btn_start1(btn_start1),
        .btn_start2(btn_start2),
        .coin_out  (coin_out),
        .start1_out(start1_out),
        .start2_out(start2_out),
        .game_reset(game_reset),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Expected {busy, game_reset, start2_out, start1_out, coin_out} in cycle c.
    function automatic logic [4:0] exp_out(input int scn, input int c);
        bit co, s1, s2, gr, bz;
        co = 1'b0; s1 = 1'b0; s2 = 1'b0; gr = 1'b0; bz = 1'b0;
        case (scn)
            1: begin co = in_rng(c, 12, 15); bz = in_rng(c, 12, 18); end
            2: begin
                co = in_rng(c, 12, 15); s1 = in_rng(c, 20, 23); s2 = in_rng(c, 28, 31);
                bz = in_rng(c, 12, 18) | in_rng(c, 20, 26) | in_rng(c, 28, 34);
            end
            3: begin
                s1 = in_rng(c, 12, 15) | in_rng(c, 20, 23);
                bz = in_rng(c, 12, 18) | in_rng(c, 20, 26);
            end
            4: begin co = in_rng(c, 12, 13); gr = in_rng(c, 14, 21); bz = in_rng(c, 12, 21); end
            5: begin co = in_rng(c, 14, 17); bz = in_rng(c, 14, 20); end
            6: begin co = in_rng(c, 12, 13); bz = in_rng(c, 12, 13); end
            default: begin end
        endcase
        return {bz, gr, s2, s1, co};
    endfunction

    task automatic apply_inputs(input int scn, input int c);
        status     = 32'h0000_0000;
        btn_coin   = 1'b0;
        btn_start1 = 1'b0;
        btn_start2 = 1'b0;
        reset      = 1'b0;
        case (scn)
            1: begin
                status[1]     = (c >= 10);
                status[31:6]  = 26'h2AA_AAAA;
                status[0]     = c[0];
                status[4]     = c[1];
            end
            2: begin
                btn_coin   = (c >= 10);
                btn_start1 = (c >= 10);
                btn_start2 = (c >= 10);
            end
            3: btn_start1 = in_rng(c, 10, 11) | (c == 13) | (c == 15) | (c == 17);
            4: begin
                status[1]  = (c >= 10);
                btn_start2 = (c >= 11);
                status[5]  = (c >= 13);
            end
            5: btn_coin = (c < 10) || (c >= 12);
            6: begin
                status[1]  = (c >= 10);
                btn_start1 = (c >= 11);
                reset      = in_rng(c, 13, 14);
            end
            default: begin end
        endcase
    endtask

    task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b (busy,grst,s2,s1,coin)", tag, got, exp);
        end
    endtask

    task automatic run_scenario(input int scn);
        apply_inputs(scn, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        for (int c = 0; c <= 40; c++) begin
            check_vec($sformatf("s%0d_c%0d", scn, c),
                      {busy, game_reset, start2_out, start1_out, coin_out},
                      exp_out(scn, c));
            apply_inputs(scn, c);
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        for (int s = 1; s <= 6; s++) begin
            run_scenario(s);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
